// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if: fetch-stage bus bundling hazard controls, imem port and IF/ID outputs.
interface if_id_fetch_stage_if #(parameter int CNT_W = 16);
   logic             stall;
   logic             branch_taken;
   logic [31:0]      branch_target;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_rdata;
   logic [31:0]      IF_ID_PC;
   logic [31:0]      IF_ID_instr;
   logic             IF_ID_valid;
   logic             IF_ID_is_Branch;
   logic [4:0]       IF_ID_rs1;
   logic [4:0]       IF_ID_rs2;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   modport master (
      input  stall, branch_taken, branch_target, imem_rdata,
      output imem_addr, IF_ID_PC, IF_ID_instr, IF_ID_valid, IF_ID_is_Branch,
             IF_ID_rs1, IF_ID_rs2, stall_cnt, flush_cnt
   );
   modport slave (
      output stall, branch_taken, branch_target, imem_rdata,
      input  imem_addr, IF_ID_PC, IF_ID_instr, IF_ID_valid, IF_ID_is_Branch,
             IF_ID_rs1, IF_ID_rs2, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: RV32I PC generation, IF/ID register with stall/redirect, and hazard pre-decode.
module if_id_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input logic                clk,
   input logic                rst,
   if_id_fetch_stage_if.master bus
);
   logic [31:0]      pc, id_pc, id_instr;
   logic             id_valid;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       op;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         id_pc     <= '0;
         id_instr  <= NOP_INSTR;
         id_valid  <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (bus.stall) begin
         stall_cnt <= stall_cnt + CNT_W'(!(&stall_cnt));
      end else if (bus.branch_taken) begin
         pc        <= {bus.branch_target[31:2], 2'b00};
         id_pc     <= pc;
         id_instr  <= NOP_INSTR;
         id_valid  <= 1'b0;
         flush_cnt <= flush_cnt + CNT_W'(!(&flush_cnt));
      end else begin
         pc       <= pc + 32'd4;
         id_pc    <= pc;
         id_instr <= bus.imem_rdata;
         id_valid <= 1'b1;
      end
   end
   // unused register fields are zeroed so the hazard unit never sees false dependencies
   assign op                  = id_instr[6:0];
   assign bus.imem_addr       = pc;
   assign bus.IF_ID_PC        = id_pc;
   assign bus.IF_ID_instr     = id_instr;
   assign bus.IF_ID_valid     = id_valid;
   assign bus.IF_ID_is_Branch = id_valid && (op == 7'b1100011 || op == 7'b1100111);
   assign bus.IF_ID_rs1       = (id_valid && op != 7'b0110111 && op != 7'b0010111 && op != 7'b1101111)
                                ? id_instr[19:15] : 5'd0;
   assign bus.IF_ID_rs2       = (id_valid && (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011))
                                ? id_instr[24:20] : 5'd0;
   assign bus.stall_cnt       = stall_cnt;
   assign bus.flush_cnt       = flush_cnt;
endmodule
